pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised front-end pipeline stage register carrying instruction, PC and branch-prediction fields between fetch and decode (and reusable between later stages). It adds a valid/ready handshake, back-pressure stall, flush (squash) and an optional skid buffer, which together give full throughput with a registered `in_ready`. It sits between the fetch unit and the decoder and absorbs decode-side stalls without dropping or duplicating instructions.

## Interface
- `INSTR_W`, default 32: instruction field width.
- `XLEN`, default 32: PC and predicted-target width.
- `NOP_INSTR`, default 32'h00000013: value driven on `out_instr` after reset or flush (`addi x0,x0,0`).
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `flush` input, 1 bit: squash all held entries and discard this cycle's input.
- `in_valid` input, 1 bit: upstream presents an entry.
- `in_ready` output, 1 bit: stage can accept; transfer occurs when `in_valid && in_ready`.
- `in_instr` input, `INSTR_W` bits: fetched instruction.
- `in_pc` input, `XLEN` bits: PC of the instruction.
- `in_pred_taken` input, 1 bit: branch predicted taken.
- `in_pred_target` input, `XLEN` bits: predicted branch target.
- `out_valid` output, 1 bit: entry presented downstream.
- `out_ready` input, 1 bit: downstream accepts; transfer occurs when `out_valid && out_ready`.
- `out_instr`, `out_pc`, `out_pred_taken`, `out_pred_target` outputs, widths as inputs: registered entry.

## Operation
- Main register (M) drives the outputs directly, with no combinational path from `in_*` to `out_*`.
- With skid, a second register (S) holds one extra entry. Occupancy states are EMPTY (0), ONE (M valid) and FULL (M and S valid).
- EMPTY: an accepted input loads M, giving ONE.
- ONE: pop without push gives EMPTY. Push with pop reloads M and stays ONE. Push without pop loads S and gives FULL. Otherwise M holds.
- FULL: pop moves S into M and gives ONE. No input is accepted in FULL.
- `in_ready` is registered and equals `state != FULL` for the next cycle.
- Outputs hold stable while `out_valid && !out_ready`; the entry presented must not change.
- `flush` moves the stage to EMPTY next cycle and takes priority over push and pop.
  - `out_instr` becomes `NOP_INSTR`; `out_pred_taken`, `out_pc` and `out_pred_target` become 0.
  - Input offered in the flush cycle counts as consumed if `in_ready` was 1, and is discarded.
- Going to EMPTY via pop (not flush) leaves data fields holding their last value, with `out_valid` = 0.
- Widths pass through unchanged, with no arithmetic.

## Timing
- Latency from input to output is 1 cycle: an entry accepted at edge N shows `out_valid` = 1 after edge N.
- Throughput is 1 entry/cycle while `out_ready` = 1.
- With a stalled consumer, the stage accepts at most 2 entries (skid) or 1 (no skid) before `in_ready` drops.
- When `out_ready` rises in FULL, `in_ready` returns to 1 one cycle after the pop.
- Reset values, driven from the edge where `reset` = 1:
  - `out_valid` = 0, `out_instr` = `NOP_INSTR`, other data fields = 0, state = EMPTY.
  - `in_ready` = 1 with skid; the combinational value without skid is 1.
- Reset mid-operation discards both entries; no transfer is reported for that cycle.
- `reset` overrides `flush`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined: S register present, registered `in_ready`, FULL state as above.
- Not defined:
  - Single register M, states EMPTY and ONE only.
  - `in_ready` is combinational, `!out_valid || out_ready`.
  - Full throughput is kept, but there is a combinational `out_ready`→`in_ready` path.
  - Flush and reset behaviour are unchanged.

## Test plan
- Streaming: reset, then 8 back-to-back inputs (pc 0x0,0x4…0x1C) with `out_ready` = 1 → outputs appear 1 cycle later, in order, none lost or duplicated, `in_ready` constantly 1.
- Stall: `out_ready` = 0 while streaming.
  - Skid: accepts pc 0x0 and 0x4, `in_ready` falls, `out_pc` stays 0x0. Release → 0x0, 0x4, 0x8 delivered in order.
  - No skid: only 0x0 is held.
- Flush in FULL with `in_valid` = 1 (pc 0x40) → next cycle `out_valid` = 0, `out_instr` = 0x00000013, `out_pred_target` = 0, pc 0x40 never appears.
- Predicted branch: input `in_pred_taken` = 1, `in_pred_target` = 0x80 with pc 0x10 → `out_pred_taken` = 1, `out_pred_target` = 0x80 paired with `out_pc` 0x10.
- Reset while ONE with `out_ready` = 0 → next cycle `out_valid` = 0, `out_instr` = `NOP_INSTR`, `in_ready` = 1. A subsequent input is delivered normally.
- Parameter sweep: `XLEN` = 64 and `INSTR_W` = 16, pc 0xFFFF_FFFF_0000_0004 → passed through bit-exact.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Fetch->decode pipeline stage register: valid/ready handshake, stall, flush.
// Define PIPE_STAGE_SKID_EN for a skid entry and a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned          INSTR_W   = 32,
    parameter int unsigned          XLEN      = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h00000013)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               in_pred_taken,
    input  logic [XLEN-1:0]    in_pred_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_pred_taken,
    output logic [XLEN-1:0]    out_pred_target
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
        logic               pred_taken;
        logic [XLEN-1:0]    pred_target;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        instr:       NOP_INSTR,
        pc:          '0,
        pred_taken:  1'b0,
        pred_target: '0
    };

    state_e state_q, state_d;
    entry_t m_q, m_d;
    entry_t in_e;
    logic   push, pop;

    assign in_e      = '{instr: in_instr, pc: in_pc, pred_taken: in_pred_taken,
                         pred_target: in_pred_target};
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_instr       = m_q.instr;
    assign out_pc          = m_q.pc;
    assign out_pred_taken  = m_q.pred_taken;
    assign out_pred_target = m_q.pred_target;

`ifdef PIPE_STAGE_SKID_EN
    entry_t s_q, s_d;
    logic   in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            state_d = EMPTY;
            m_d     = RESET_ENTRY;
        end else begin
            unique case (state_q)
                EMPTY: if (push) begin
                    m_d     = in_e;
                    state_d = ONE;
                end
                ONE: begin
                    if (push && !pop) begin
                        s_d     = in_e;
                        state_d = FULL;
                    end else if (push) begin
                        m_d = in_e;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    m_d     = s_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
        // in_ready for next cycle mirrors the next occupancy
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            m_q        <= RESET_ENTRY;
            s_q        <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
        end
    end
`else
    // Without the skid entry, acceptance depends on the consumer this cycle
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        if (flush) begin
            state_d = EMPTY;
            m_d     = RESET_ENTRY;
        end else begin
            unique case (state_q)
                EMPTY: if (push) begin
                    m_d     = in_e;
                    state_d = ONE;
                end
                ONE: begin
                    if (push) begin
                        m_d = in_e;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            m_q     <= RESET_ENTRY;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
        end
    end
`endif

endmodule
